// File: rtl/decode_issue_ctrl_pkg.sv
// InsnDecodePkg: instruction classes and opcode classification for decode.
// Ports: none. Provides InsnClass, opcode constants and the classify helpers.
package InsnDecodePkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ALU     = 3'd0,
        BRANCH  = 3'd1,
        CBRANCH = 3'd2,
        MTS     = 3'd3,
        MFS     = 3'd4
    } InsnClass;

    // Unconditional control transfer (JAL / JALR).
    function automatic logic insn_is_branch(input logic [31:0] insn);
        return (insn[6:0] == OP_JAL) || (insn[6:0] == OP_JALR);
    endfunction

    function automatic logic insn_is_cbranch(input logic [31:0] insn);
        return insn[6:0] == OP_BRANCH;
    endfunction

    // CSRRW / CSRRWI: write to special state.
    function automatic logic insn_is_mts(input logic [31:0] insn);
        return (insn[6:0] == OP_SYSTEM) && (insn[13:12] == 2'b01);
    endfunction

    // CSRRS / CSRRC and immediate forms: read of special state.
    function automatic logic insn_is_mfs(input logic [31:0] insn);
        return (insn[6:0] == OP_SYSTEM) && insn[13];
    endfunction

    function automatic InsnClass insn_classify(input logic [31:0] insn);
        InsnClass c;
        c = ALU;
        unique case (1'b1)
            insn_is_branch(insn):  c = BRANCH;
            insn_is_cbranch(insn): c = CBRANCH;
            insn_is_mts(insn):     c = MTS;
            insn_is_mfs(insn):     c = MFS;
            default:               c = ALU;
        endcase
        return c;
    endfunction

    // Special-register accesses must execute with an empty backend.
    function automatic logic class_is_serial(input InsnClass c);
        return (c == MTS) || (c == MFS);
    endfunction

    function automatic logic class_is_branch(input InsnClass c);
        return (c == BRANCH) || (c == CBRANCH);
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_inflight_counter.sv
// inflight_counter: saturating up/down count of issued, unretired instructions.
// Ports: clk, rst_n, inc (issue), dec (retire), count, full (==MAX), empty (==0).
module inflight_counter #(
    parameter int MAX = 7,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full,
    output logic         empty
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt;

    // Simultaneous inc and dec cancel; both ends saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != MAX_C)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign count = cnt;
    assign full  = (cnt == MAX_C);
    assign empty = (cnt == '0);

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: single-entry decode holding register with issue throttling,
// serialization of special-register accesses and branch-resolution waits.
// Ports: fetch_valid/ready/insn/pc in; issue_valid/ready/insn/pc/class out;
// retire, br_resolve, br_mispredict in; flush pulse and inflight count out.
module decode_issue_ctrl
    import InsnDecodePkg::*;
#(
    parameter int MAX_INFLIGHT = 7,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid,
    input  logic [31:0]      fetch_insn,
    input  logic [31:0]      fetch_pc,
    output logic             fetch_ready,
    output logic             issue_valid,
    output logic [31:0]      issue_insn,
    output logic [31:0]      issue_pc,
    output logic [2:0]       issue_class,
    input  logic             issue_ready,
    input  logic             retire,
    input  logic             br_resolve,
    input  logic             br_mispredict,
    output logic             flush,
    output logic [CNT_W-1:0] inflight
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        PRE_DRAIN  = 2'd1,
        BR_WAIT    = 2'd2,
        POST_DRAIN = 2'd3
    } ctrl_state_e;

    ctrl_state_e state;
    ctrl_state_e state_nxt;

    logic        held;
    logic [31:0] held_insn;
    logic [31:0] held_pc;
    InsnClass    held_class;

    logic fetch_fire;
    logic issue_fire;
    logic kill;
    logic held_serial;
    logic held_branch;
    logic cnt_full;
    logic cnt_empty;

    assign fetch_fire  = fetch_valid && fetch_ready;
    assign issue_fire  = issue_valid && issue_ready;
    assign held_serial = held && class_is_serial(held_class);
    assign held_branch = held && class_is_branch(held_class);

    // Wrong-path redirect: the held entry belongs to the mispredicted path.
    assign kill = (state == BR_WAIT) && br_resolve && br_mispredict;

    inflight_counter #(
        .MAX (MAX_INFLIGHT),
        .W   (CNT_W)
    ) u_inflight (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (issue_fire),
        .dec   (retire),
        .count (inflight),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (held_serial) begin
                    state_nxt = PRE_DRAIN;
                end else if (issue_fire && held_branch) begin
                    state_nxt = BR_WAIT;
                end
            end
            PRE_DRAIN: begin
                if (issue_fire) begin
                    state_nxt = POST_DRAIN;
                end
            end
            BR_WAIT: begin
                if (br_resolve) begin
                    state_nxt = RUN;
                end
            end
            POST_DRAIN: begin
                if (cnt_empty) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        issue_valid = 1'b0;
        fetch_ready = 1'b0;
        unique case (state)
            RUN: begin
                issue_valid = held && !held_serial && !cnt_full;
                fetch_ready = !held || (issue_valid && issue_ready);
            end
            PRE_DRAIN: begin
                issue_valid = held && cnt_empty;
            end
            BR_WAIT: begin
                // Refill allowed, issue blocked until resolve.
                fetch_ready = !held;
            end
            POST_DRAIN: begin
                issue_valid = 1'b0;
            end
            default: begin
                issue_valid = 1'b0;
            end
        endcase
        fetch_ready = fetch_ready && !flush && rst_n;
    end

    // Kill wins over a same-cycle refill so no wrong-path opcode survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held       <= 1'b0;
            held_insn  <= '0;
            held_pc    <= '0;
            held_class <= ALU;
        end else if (kill) begin
            held <= 1'b0;
        end else if (fetch_fire) begin
            held       <= 1'b1;
            held_insn  <= fetch_insn;
            held_pc    <= fetch_pc;
            held_class <= insn_classify(fetch_insn);
        end else if (issue_fire) begin
            held <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush <= 1'b0;
        end else begin
            flush <= kill;
        end
    end

    assign issue_insn  = held_insn;
    assign issue_pc    = held_pc;
    assign issue_class = held_class;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb_decode_issue_ctrl: directed scenarios plus random traffic, checked by a
// rule-level model and an issue-stream scoreboard.
module tb_decode_issue_ctrl;

    localparam int MAXI = 7;
    localparam int W    = 3;

    localparam logic [2:0] C_ALU = 3'd0;
    localparam logic [2:0] C_BR  = 3'd1;
    localparam logic [2:0] C_CBR = 3'd2;
    localparam logic [2:0] C_MTS = 3'd3;
    localparam logic [2:0] C_MFS = 3'd4;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [2:0]  cls;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_valid;
    logic [31:0]  fetch_insn;
    logic [31:0]  fetch_pc;
    logic         fetch_ready;
    logic         issue_valid;
    logic [31:0]  issue_insn;
    logic [31:0]  issue_pc;
    logic [2:0]   issue_class;
    logic         issue_ready;
    logic         retire;
    logic         br_resolve;
    logic         br_mispredict;
    logic         flush;
    logic [W-1:0] inflight;

    int checks = 0;
    int errors = 0;
    logic [31:0] pc_next;

    always #5 clk = ~clk;

    decode_issue_ctrl #(
        .MAX_INFLIGHT (MAXI),
        .CNT_W        (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_valid   (fetch_valid),
        .fetch_insn    (fetch_insn),
        .fetch_pc      (fetch_pc),
        .fetch_ready   (fetch_ready),
        .issue_valid   (issue_valid),
        .issue_insn    (issue_insn),
        .issue_pc      (issue_pc),
        .issue_class   (issue_class),
        .issue_ready   (issue_ready),
        .retire        (retire),
        .br_resolve    (br_resolve),
        .br_mispredict (br_mispredict),
        .flush         (flush),
        .inflight      (inflight)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Opcode classes straight from the RISC-V encodings.
    function automatic logic [2:0] ref_class(input logic [31:0] i);
        int f3;
        f3 = int'(i[14:12]);
        if (i[6:0] == 7'h6f || i[6:0] == 7'h67) return C_BR;
        if (i[6:0] == 7'h63) return C_CBR;
        if (i[6:0] == 7'h73) begin
            if (f3 == 1 || f3 == 5) return C_MTS;
            if (f3 == 2 || f3 == 3 || f3 == 6 || f3 == 7) return C_MFS;
        end
        return C_ALU;
    endfunction

    function automatic logic [31:0] mk(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: r[6:0] = 7'h13;
            1: r[6:0] = 7'h33;
            2: r[6:0] = 7'h6f;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5: begin r[6:0] = 7'h73; r[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5; end
            6: begin r[6:0] = 7'h73; r[14:12] = 3'd2; end
            7: begin r[6:0] = 7'h73; r[14:12] = 3'd0; end
            default: r = $urandom;
        endcase
        return r;
    endfunction

    // ---------------- reference model (rule level) ----------------
    ent_t m_q[$];
    ent_t sb_q[$];
    int   m_inflight;
    bit   m_brwait, m_post, m_armed, m_flush;
    bit   h, ser, ev, fr, fire, kill;
    int   cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_inflight = 0;
            m_brwait   = 0;
            m_post     = 0;
            m_armed    = 0;
            m_flush    = 0;
            chk("rst_fetch_ready", fetch_ready, 0);
            chk("rst_issue_valid", issue_valid, 0);
            chk("rst_flush", flush, 0);
            chk("rst_inflight", inflight, 0);
            chk("rst_issue_data", {issue_insn, issue_pc, issue_class}, 0);
        end else begin
            h   = m_q.size() != 0;
            ser = 0;
            if (h) ser = (m_q[0].cls == C_MTS) || (m_q[0].cls == C_MFS);
            // Special-register op may only go once it has waited and the backend is empty.
            ev = h && !m_brwait && !m_post && !m_flush &&
                 (ser ? (m_armed && m_inflight == 0) : (m_inflight < MAXI));
            fire = ev && issue_ready;
            fr = !m_flush && !m_post && !m_armed && (!h || fire);

            chk("inflight", inflight, m_inflight);
            chk("flush", flush, m_flush);
            chk("issue_valid", issue_valid, ev);
            chk("fetch_ready", fetch_ready, fr);

            cur  = m_inflight;
            kill = m_brwait && br_resolve && br_mispredict;
            if (fire && !retire) m_inflight++;
            else if (retire && !fire && m_inflight > 0) m_inflight--;

            if (m_post && cur == 0) m_post = 0;
            if (fire && ser) m_post = 1;
            m_armed = fire ? 0 : (ser && !m_brwait);

            if (m_brwait && br_resolve) m_brwait = 0;
            if (fire) begin
                if (m_q[0].cls == C_BR || m_q[0].cls == C_CBR) m_brwait = 1;
                void'(m_q.pop_front());
            end
            m_flush = kill;
            if (kill) begin
                repeat (m_q.size()) if (sb_q.size() != 0) void'(sb_q.pop_back());
                m_q.delete();
            end else if (fetch_valid && fr) begin
                m_q.push_back({fetch_insn, fetch_pc, ref_class(fetch_insn)});
                sb_q.push_back({fetch_insn, fetch_pc, ref_class(fetch_insn)});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit         prev_stall;
    logic [66:0] prev_out;
    ent_t       got;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("issue_stable", {issue_insn, issue_pc, issue_class}, prev_out);
            if (issue_valid && issue_ready) begin
                chk("issue_has_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    chk("issue_data", {issue_insn, issue_pc, issue_class}, got);
                end
            end
            prev_stall = issue_valid && !issue_ready;
            prev_out   = {issue_insn, issue_pc, issue_class};
        end
    end

    // ---------------- driver ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic send(input logic [31:0] insn);
        int n;
        fetch_valid = 1'b1;
        fetch_insn  = insn;
        fetch_pc    = pc_next;
        pc_next     = pc_next + 32'd4;
        #1;
        n = 0;
        while (!fetch_ready && n < 60) begin
            cyc();
            n++;
        end
        chk("send_accept", fetch_ready, 1);
        cyc();
        fetch_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        retire = 1'b1;
        #1;
        n = 0;
        while (inflight != 0 && n < 40) begin
            cyc();
            n++;
        end
        retire = 1'b0;
        chk("drain_done", inflight, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; fetch_valid = 0; fetch_insn = 0; fetch_pc = 0;
        issue_ready = 0; retire = 0; br_resolve = 0; br_mispredict = 0;
        pc_next = 32'h1000;
        run(3);
        rst_n = 1;
        run(1);

        // ALU capture, one-cycle latency, first issue
        send(mk(0));
        chk("first_issue_valid", issue_valid, 1);
        chk("first_issue_class", issue_class, C_ALU);
        issue_ready = 1;
        run(1);
        chk("first_inflight", inflight, 1);
        drain();

        // three ALU then a special-register write
        send(mk(0)); send(mk(1)); send(mk(0));
        run(1);
        chk("three_inflight", inflight, 3);
        send(mk(5));
        run(3);
        chk("mts_blocked", issue_valid, 0);
        retire = 1; run(3); retire = 0;
        chk("mts_ready_after_drain", issue_valid, 1);
        run(1);
        chk("post_drain_fetch_low", fetch_ready, 0);
        run(2);
        chk("post_drain_still_low", fetch_ready, 0);
        retire = 1; run(1); retire = 0;
        run(1);
        chk("run_after_drain", fetch_ready, 1);

        // mispredicted branch drops held ALU
        send(mk(4)); send(mk(0));
        run(2);
        chk("br_wait_blocks", issue_valid, 0);
        br_resolve = 1; br_mispredict = 1; run(1);
        br_resolve = 0; br_mispredict = 0;
        chk("mispredict_flush", flush, 1);
        chk("mispredict_fetch_low", fetch_ready, 0);
        run(1);
        chk("flush_one_cycle", flush, 0);
        drain();

        // correctly predicted branch keeps held ALU
        send(mk(2)); send(mk(1));
        run(2);
        br_resolve = 1; br_mispredict = 0; run(1);
        br_resolve = 0;
        chk("predict_ok_issue", issue_valid, 1);
        chk("predict_ok_noflush", flush, 0);
        run(1);
        drain();

        // saturation at MAX_INFLIGHT
        repeat (8) send(mk(0));
        chk("full_inflight", inflight, MAXI);
        chk("full_blocks_issue", issue_valid, 0);
        run(2);
        retire = 1; run(1); retire = 0;
        run(1);
        chk("refill_inflight", inflight, MAXI);

        // retire and issue together at four
        issue_ready = 0;
        retire = 1; run(3); retire = 0;
        send(mk(1));
        chk("four_before", inflight, 4);
        retire = 1; issue_ready = 1; run(1);
        retire = 0; issue_ready = 0;
        chk("four_after", inflight, 4);

        // asynchronous reset while waiting to drain
        send(mk(6));
        run(2);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async_fetch_ready", fetch_ready, 0);
        chk("async_issue_valid", issue_valid, 0);
        chk("async_inflight", inflight, 0);
        chk("async_flush", flush, 0);
        chk("async_data", {issue_insn, issue_pc, issue_class}, 0);
        run(2);
        rst_n = 1;
        run(1);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            fetch_valid   = $urandom_range(0, 3) != 0;
            fetch_insn    = mk($urandom_range(0, 11));
            fetch_pc      = $urandom;
            issue_ready   = $urandom_range(0, 3) != 0;
            retire        = $urandom_range(0, 2) == 0;
            br_resolve    = $urandom_range(0, 5) == 0;
            br_mispredict = $urandom_range(0, 1) != 0;
            cyc();
        end
        fetch_valid = 0; issue_ready = 0; retire = 0;
        br_resolve = 0; br_mispredict = 0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
DECODE_ISSUE_CTRL -- requirements
Module: decode_issue_ctrl

Interface
REQ-001 Parameter MAX_INFLIGHT, default 7; maximum number of issued, not-yet-retired instructions.
REQ-002 Parameter CNT_W, default 3; inflight counter width, SHALL satisfy 2**CNT_W > MAX_INFLIGHT.
REQ-003 clk  input  1  single core clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fetch_valid  input  1  fetch presents an instruction.
REQ-006 fetch_insn  input  32  InsnOpcode from fetch.
REQ-007 fetch_pc  input  32  PC of fetch_insn.
REQ-008 fetch_ready  output  1  decode accepts this cycle.
REQ-009 issue_valid  output  1  held instruction offered to backend.
REQ-010 issue_insn  output  32  held opcode.
REQ-011 issue_pc  output  32  held PC.
REQ-012 issue_class  output  3  InsnClass of held opcode.
REQ-013 issue_ready  input  1  backend accepts.
REQ-014 retire  input  1  one instruction retired this cycle.
REQ-015 br_resolve  input  1  outstanding branch resolved (one-cycle pulse).
REQ-016 br_mispredict  input  1  qualifies br_resolve; redirect required.
REQ-017 flush  output  1  one-cycle pulse; fetch redirect in progress.
REQ-018 inflight  output  CNT_W  current inflight count.

Function
REQ-019 Fetch handshake fires on fetch_valid && fetch_ready; issue handshake fires on issue_valid && issue_ready.
REQ-020 Single-entry holding register; accepted instruction SHALL appear on issue_* the next cycle (latency 1).
REQ-021 Classification at capture, priority order: BRANCH (insn_is_branch), CBRANCH (insn_is_cbranch), MTS, MFS, else ALU.
REQ-022 States: RUN, PRE_DRAIN, BR_WAIT, POST_DRAIN.
REQ-023 RUN: fetch_ready = state==RUN && (!held || issue fires this cycle) && !flush; issue_valid = held && inflight < MAX_INFLIGHT && class not MTS/MFS.
REQ-024 Held MTS/MFS in RUN: go PRE_DRAIN, issue_valid low until inflight==0.
REQ-025 PRE_DRAIN: issue_valid high when inflight==0; on issue fire go POST_DRAIN; fetch_ready low.
REQ-026 POST_DRAIN: fetch_ready and issue_valid low until inflight==0, then RUN.
REQ-027 Issue fire of BRANCH/CBRANCH: go BR_WAIT; fetch_ready may refill holding register but issue_valid SHALL stay low.
REQ-028 BR_WAIT, br_resolve && !br_mispredict: go RUN; held entry retained.
REQ-029 BR_WAIT, br_resolve && br_mispredict: drop held entry, flush=1 next cycle, fetch_ready=0 that cycle, go RUN.
REQ-030 br_resolve outside BR_WAIT SHALL be ignored.
REQ-031 inflight +1 on issue fire, -1 on retire, unchanged when both same cycle.
REQ-032 retire at inflight==0 SHALL leave count 0; issue SHALL never push count above MAX_INFLIGHT.
REQ-033 issue_insn/issue_pc/issue_class SHALL be stable while issue_valid && !issue_ready.

Reset
REQ-034 rst_n low: state RUN, held empty, inflight 0, issue_valid 0, flush 0, fetch_ready 0, issue_insn/pc/class 0.
REQ-035 First cycle after release: fetch_ready 1.
REQ-036 Reset mid-operation SHALL discard held entry and pending drain/branch wait immediately.

Structure
REQ-037 InsnClass enum (ALU, BRANCH, CBRANCH, MTS, MFS) and insn_classify function SHALL live in InsnDecodePkg.
REQ-038 Controller state enum SHALL be local to decode_issue_ctrl.
REQ-039 Inflight counter SHALL be sub-module inflight_counter (inc, dec, saturation bounds, count).

Verification
REQ-040 Reset, then ALU opcode with fetch_valid=1 at cycle 1 -> issue_valid=1 at cycle 2, issue_class=ALU, inflight=1 after issue with issue_ready=1.
REQ-041 Three ALU issued (inflight=3), then MTS -> issue_valid low until three retire pulses, MTS issues, fetch_ready low until its retire, then RUN.
REQ-042 Branch issued, next ALU held; br_resolve=1, br_mispredict=1 -> flush=1 one cycle, held ALU never issued, fetch_ready=0 that cycle.
REQ-043 Same with br_mispredict=0 -> held ALU issues cycle after resolve, flush stays 0.
REQ-044 MAX_INFLIGHT=7 issues without retire -> 8th held, issue_valid=0; one retire -> 8th issues, inflight stays 7.
REQ-045 retire and issue same cycle at inflight=4 -> inflight=4; rst_n low during PRE_DRAIN -> all outputs reset values asynchronously.
